instruction_loader: RTL
=======================

// Module: instruction_loader
// PURPOSE
//   Write-side companion of the instruction ROM. Takes a stream of machine-code words
//   (valid/ready) and writes them into a writable instruction memory, starting at
//   address 0. Holds the processor in stall while loading, so programs can be
//   replaced without re-running $readmemb.
//   Sits between the host/test link and the instruction memory write port.
// PARAMETERS
//   INSTRUCTION_WIDTH  10  width of one instruction word
//   ADDR_BITS          8   memory address width; depth = 2**ADDR_BITS (256)
// PORTS
//   clk         in   1                   single clock, all logic on rising edge
//   rst_n       in   1                   synchronous, active-low reset
//   start       in   1                   1-cycle pulse: begin a new program load
//   in_valid    in   1                   in_data/in_last are valid this cycle
//   in_data     in   INSTRUCTION_WIDTH   instruction word to store
//   in_last     in   1                   marks the final word of the program
//   in_ready    out  1                   loader accepts a word this cycle
//   mem_we      out  1                   instruction memory write enable
//   mem_addr    out  ADDR_BITS           write address
//   mem_wdata   out  INSTRUCTION_WIDTH   write data
//   cpu_hold    out  1                   stall PC/processor while high
//   done        out  1                   program fully loaded
//   error       out  1                   overflow: memory full before in_last
//   word_count  out  ADDR_BITS+1         words written in the current/last load
// BEHAVIOUR
//   - Reset (rst_n=0 at a clk edge): state=IDLE; all outputs 0; word_count=0.
//     A reset during LOAD aborts it; a write pending for the next cycle is dropped.
//   - States: IDLE, LOAD, DONE, ERROR (2-bit encoding).
//   - IDLE:  in_ready=0, cpu_hold=0. start=1 -> LOAD; next_addr=0, word_count=0.
//   - LOAD:  in_ready=1, cpu_hold=1. Accept = in_valid & in_ready.
//     On accept at cycle N: at cycle N+1 mem_we=1, mem_addr=next_addr, mem_wdata=in_data.
//     next_addr and word_count +1 per accept. Write latency: exactly 1 cycle.
//     Back-to-back accepts produce back-to-back writes.
//     Accept with in_last=1 -> DONE.
//     Accept at next_addr=2**ADDR_BITS-1 with in_last=0 -> ERROR.
//     That word is still written.
//     Accept at the last address with in_last=1 -> DONE (exact fit, no error).
//     start during LOAD is ignored.
//   - DONE:  in_ready=0, cpu_hold=0, done=1. Held until the next start,
//     which -> LOAD and clears done and word_count.
//   - ERROR: in_ready=0, cpu_hold=1, error=1. Held until start (-> LOAD, clears error)
//     or reset.
//   - mem_we is 1 only in the cycle after an accept; otherwise 0.
//     mem_addr/mem_wdata hold their last value when mem_we=0.
//   - next_addr never wraps: no write ever goes to address 0 twice within one load.
//   - word_count saturates naturally at 2**ADDR_BITS (fits in ADDR_BITS+1 bits).
//   - All outputs are registered, except in_ready, which decodes from state only.
//     in_ready has no combinational path from in_valid.
// STRUCTURE
//   - Shared header (processor defines .vh):
//     * INSTRUCTION_WIDTH / ADDR_BITS defaults
//     * loader state localparams S_IDLE=0, S_LOAD=1, S_DONE=2, S_ERROR=3
//   - Single module, no sub-modules: FSM, address counter, write-port register stage.
//   - Instruction memory gains a synchronous write port (we/addr/wdata) driven by
//     this block. Its read path stays combinational.
// TESTING
//   1 Reset: rst_n=0 for 2 cycles.
//     -> all outputs 0, state IDLE; in_valid=1 meanwhile causes no mem_we.
//   2 Load 3 words 0x001, 0x2AA, 0x3FF (last on 3rd), valid every cycle.
//     -> mem_we on 3 consecutive cycles, addr 0,1,2 with matching data;
//     -> done=1, cpu_hold=0, word_count=3.
//   3 Gapped input: valid only every 3rd cycle, 4 words.
//     -> writes only 1 cycle after each accept; addr 0..3; cpu_hold=1 throughout.
//   4 Overflow: 257 words, no in_last.
//     -> 256 writes (addr 0..255), error=1, in_ready=0 after the 256th accept;
//     -> word_count=256, no 257th write.
//   5 Exact fit: 256 words with in_last on the 256th.
//     -> done=1, error=0, word_count=256.
//   6 Reset mid-LOAD: rst_n=0 in the same cycle as accepting word 2.
//     -> no write for word 2; IDLE. Then start + 1 word -> write at addr 0.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
// instruction_loader_pkg: shared widths and loader state encoding for the instruction loader.
package instruction_loader_pkg;
    localparam int INSTRUCTION_WIDTH = 10;
    localparam int ADDR_BITS = 8;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DONE  = 2'd2,
        S_ERROR = 2'd3
    } loader_state_e;
endpackage

// File: rtl/instruction_loader.sv
// instruction_loader: streams machine-code words into the instruction memory write port,
// stalling the processor while a program is being loaded.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int IW = INSTRUCTION_WIDTH,
    parameter int AW = ADDR_BITS
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    input  logic [IW-1:0] in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [IW-1:0] mem_wdata,
    output logic          cpu_hold,
    output logic          done,
    output logic          error,
    output logic [AW:0]   word_count
);
    loader_state_e state_q, state_d;
    logic [AW:0]   word_count_q, word_count_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [IW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_we_q, mem_we_d;
    logic          cpu_hold_q, done_q, error_q;
    logic          accept;

    assign in_ready = state_q == S_LOAD;
    assign accept   = in_ready & in_valid;

    // word_count doubles as the next write address; the overflow check stops it before it wraps.
    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        mem_we_d     = accept;
        mem_addr_d   = accept ? word_count_q[AW-1:0] : mem_addr_q;
        mem_wdata_d  = accept ? in_data : mem_wdata_q;
        if (!in_ready && start) begin
            state_d      = S_LOAD;
            word_count_d = '0;
        end
        if (accept) begin
            word_count_d = word_count_q + 1'b1;
            state_d      = in_last ? S_DONE : (&word_count_q[AW-1:0]) ? S_ERROR : S_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            word_count_q <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_hold_q   <= state_d == S_LOAD || state_d == S_ERROR;
            done_q       <= state_d == S_DONE;
            error_q      <= state_d == S_ERROR;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign error      = error_q;
    assign word_count = word_count_q;
endmodule
